// File: rtl/ir_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ir_fetch_pkg
// Shared definitions for the instruction-fetch sequencer:
//   - fetch_state_e : FSM state encoding
//   - FS_LOAD/FS_NOP: IR function-select codes
//   - LH_LOW/LH_HIGH: IR half-select codes
//   - half_sel()    : which IR half the byte fetched in a given state goes to
// ---------------------------------------------------------------------------
package ir_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH0 = 2'd1,
        FETCH1 = 2'd2,
        VALID  = 2'd3
    } fetch_state_e;

    localparam logic [1:0] FS_NOP  = 2'b00;
    localparam logic [1:0] FS_LOAD = 2'b01;

    localparam logic LH_LOW  = 1'b0;
    localparam logic LH_HIGH = 1'b1;

    // The first byte (at inst_pc) lands in the low half when low_first is set,
    // the second byte lands in the other half.
    function automatic logic half_sel(input fetch_state_e st, input logic low_first);
        return (st == FETCH0) ? ~low_first : low_first;
    endfunction

endpackage

// File: rtl/ir_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// ir_fetch_ctrl_if
// Bundles every non-clock/reset signal of the fetch sequencer:
//   control  : run, flush, pc_load, pc_din
//   memory   : mem_rd, mem_addr, mem_rdata, mem_ack
//   IR drive : ir_e, ir_funsel, ir_l_h, ir_half
//   execute  : ir_valid, ir_ready, inst_pc, busy
// master = the sequencer, slave = its environment (memory, IR, execute stage).
// ---------------------------------------------------------------------------
interface ir_fetch_ctrl_if #(
    parameter int AW = 8
);
    logic          run;
    logic          flush;
    logic          pc_load;
    logic [AW-1:0] pc_din;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic          mem_ack;
    logic          ir_e;
    logic [1:0]    ir_funsel;
    logic          ir_l_h;
    logic [7:0]    ir_half;
    logic          ir_valid;
    logic          ir_ready;
    logic [AW-1:0] inst_pc;
    logic          busy;

    modport master (
        input  run, flush, pc_load, pc_din, mem_rdata, mem_ack, ir_ready,
        output mem_rd, mem_addr, ir_e, ir_funsel, ir_l_h, ir_half,
               ir_valid, inst_pc, busy
    );

    modport slave (
        output run, flush, pc_load, pc_din, mem_rdata, mem_ack, ir_ready,
        input  mem_rd, mem_addr, ir_e, ir_funsel, ir_l_h, ir_half,
               ir_valid, inst_pc, busy
    );
endinterface

// File: rtl/ir_fetch_ctrl_pc_counter.sv
// ---------------------------------------------------------------------------
// pc_counter
// AW-bit program counter with rewind, load and increment (wraps modulo 2^AW).
// Ports:
//   clk, rst      : clock, synchronous active-high reset (pc <= RESET_PC)
//   rewind_i      : pc <= rewind_pc_i (highest priority)
//   load_i        : pc <= load_pc_i
//   inc_i         : pc <= pc + 1
//   pc_o          : current pc
// ---------------------------------------------------------------------------
module pc_counter #(
    parameter int            AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rewind_i,
    input  logic [AW-1:0] rewind_pc_i,
    input  logic          load_i,
    input  logic [AW-1:0] load_pc_i,
    input  logic          inc_i,
    output logic [AW-1:0] pc_o
);
    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (rewind_i) begin
            pc_d = rewind_pc_i;
        end else if (load_i) begin
            pc_d = load_pc_i;
        end else if (inc_i) begin
            // Natural overflow gives the all-ones -> 0 wrap.
            pc_d = pc_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/ir_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// ir_fetch_ctrl
// Fetch sequencer in front of a 16-bit instruction register. Reads two
// consecutive bytes at pc, steers each into the right IR half, then offers
// the instruction to the execute stage with a valid/ready handshake.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst   : synchronous active-high reset
//   fetch : ir_fetch_ctrl_if.master (control, memory, IR drive, execute)
// Parameters:
//   AW        : pc / address width
//   RESET_PC  : pc and inst_pc after reset
//   LOW_FIRST : 1 -> byte at pc goes to IR[7:0], byte at pc+1 to IR[15:8]
// ---------------------------------------------------------------------------
module ir_fetch_ctrl
    import ir_fetch_pkg::*;
#(
    parameter int            AW        = 8,
    parameter logic [AW-1:0] RESET_PC  = '0,
    parameter bit            LOW_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    ir_fetch_ctrl_if.master  fetch
);
    fetch_state_e  state_q;
    fetch_state_e  state_d;
    logic [AW-1:0] inst_pc_q;
    logic [AW-1:0] inst_pc_d;
    logic [AW-1:0] pc;

    logic          pc_load_en;
    logic          pc_inc_en;
    logic          pc_rewind_en;

    logic          mem_rd;
    logic          ir_e;
    logic [1:0]    ir_funsel;
    logic          ir_l_h;
    logic          ir_valid;

    pc_counter #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst         (rst),
        .rewind_i    (pc_rewind_en),
        .rewind_pc_i (inst_pc_q),
        .load_i      (pc_load_en),
        .load_pc_i   (fetch.pc_din),
        .inc_i       (pc_inc_en),
        .pc_o        (pc)
    );

    always_comb begin
        state_d      = state_q;
        inst_pc_d    = inst_pc_q;
        mem_rd       = 1'b0;
        ir_e         = 1'b0;
        ir_funsel    = FS_NOP;
        ir_l_h       = LH_LOW;
        ir_valid     = 1'b0;
        pc_load_en   = 1'b0;
        pc_inc_en    = 1'b0;
        pc_rewind_en = 1'b0;

        case (state_q)
            IDLE: begin
                // A branch target load wins over starting a fetch.
                if (fetch.pc_load) begin
                    pc_load_en = 1'b1;
                end else if (fetch.run) begin
                    inst_pc_d = pc;
                    state_d   = FETCH0;
                end
            end

            FETCH0, FETCH1: begin
                mem_rd = 1'b1;
                // Flush beats a same-cycle ack: the byte is dropped and pc
                // goes back to the start of the instruction.
                if (fetch.flush) begin
                    pc_rewind_en = 1'b1;
                    state_d      = IDLE;
                end else if (fetch.mem_ack) begin
                    ir_e      = 1'b1;
                    ir_funsel = FS_LOAD;
                    ir_l_h    = half_sel(state_q, 1'(LOW_FIRST));
                    pc_inc_en = 1'b1;
                    state_d   = (state_q == FETCH0) ? FETCH1 : VALID;
                end
            end

            VALID: begin
                ir_valid = 1'b1;
                if (fetch.ir_ready) begin
                    if (fetch.pc_load) begin
                        pc_load_en = 1'b1;
                        inst_pc_d  = fetch.pc_din;
                    end else begin
                        inst_pc_d  = pc;
                    end
                    // Going straight to FETCH0 avoids a bubble between
                    // back-to-back instructions.
                    state_d = fetch.run ? FETCH0 : IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            inst_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    assign fetch.mem_rd    = mem_rd;
    assign fetch.mem_addr  = pc;
    assign fetch.ir_e      = ir_e;
    assign fetch.ir_funsel = ir_funsel;
    assign fetch.ir_l_h    = ir_l_h;
    assign fetch.ir_half   = fetch.mem_rdata;
    assign fetch.ir_valid  = ir_valid;
    assign fetch.inst_pc   = inst_pc_q;
    assign fetch.busy      = (state_q != IDLE);
endmodule

// File: doc/ir_fetch_ctrl.md
Name: ir_fetch_ctrl

Overview:
Instruction-fetch sequencer directly upstream of the 16-bit instruction register. It reads two consecutive bytes from byte-wide memory at the program counter and steers each byte into the correct IR half. It does this by driving the IR's enable, function-select and low/high-select inputs. It then presents a valid/ready handshake to the execute stage and owns the PC, including increment, branch load and wrap.

Parameters:
AW, 8, memory address / PC width in bits
RESET_PC, 0, PC value after reset (AW bits)
LOW_FIRST, 1, 1: byte at PC goes to IR[7:0] and PC+1 to IR[15:8]; 0: reversed

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
run  in  1  permit fetching; sampled in IDLE and at handshake
flush  in  1  abort an in-progress fetch
pc_load  in  1  load PC from pc_din (branch/jump)
pc_din  in  AW  new PC value
mem_rd  out  1  byte read request
mem_addr  out  AW  read address, equals pc
mem_rdata  in  8  read byte, valid in the mem_ack cycle
mem_ack  in  1  read completes this cycle (latency of 1..n cycles)
ir_e  out  1  IR enable
ir_funsel  out  2  IR function select
ir_l_h  out  1  IR half select (1 = [15:8])
ir_half  out  8  byte routed to IR, equals mem_rdata
ir_valid  out  1  IR holds a complete instruction
ir_ready  in  1  execute stage accepts the instruction
inst_pc  out  AW  address of the first byte of the current instruction
busy  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE; pc = RESET_PC; inst_pc = RESET_PC; mem_rd = 0; ir_e = 0; ir_funsel = 2'b00; ir_l_h = 0; ir_valid = 0; busy = 0.
- States: IDLE, FETCH0, FETCH1, VALID. All outputs are combinational from state and inputs. pc and inst_pc are registered.
- IDLE:
  - pc_load=1: pc <= pc_din and stay in IDLE that cycle.
  - Otherwise, run=1: inst_pc <= pc and go to FETCH0.
- FETCH0 / FETCH1:
  - mem_rd = 1 and mem_addr = pc, held until mem_ack.
  - In the mem_ack cycle, combinationally: ir_e = 1, ir_funsel = 2'b01 (load), ir_l_h = half select.
  - Half select is FETCH0: !LOW_FIRST; FETCH1: LOW_FIRST.
  - At that edge pc <= pc+1, modulo 2^AW, so wrap from all-ones to 0 is legal. The instruction may straddle the wrap.
  - FETCH0 -> FETCH1 on ack; FETCH1 -> VALID on ack.
  - Without ack: ir_e = 0 and ir_funsel = 2'b00.
- Fetch latency with single-cycle ack: 2 cycles from FETCH0 entry to ir_valid.
- VALID:
  - ir_valid = 1, mem_rd = 0, ir_e = 0.
  - IR contents and inst_pc are stable until the handshake.
- Handshake (ir_valid & ir_ready):
  - pc_load=1 takes priority: pc <= pc_din.
  - Next state is FETCH0 if run=1, otherwise IDLE. inst_pc <= the new pc (pc_din if loaded).
  - Back-to-back fetch is allowed, with no bubble cycle.
- run=0 during FETCH0/FETCH1: the current instruction is still completed. A partial IR is never abandoned due to run.
- flush=1 in FETCH0/FETCH1:
  - Next state IDLE; pc <= inst_pc (rewind); mem_rd still drives that cycle, but any mem_ack in the flush cycle is ignored (ir_e = 0).
  - flush has priority over mem_ack.
  - flush in IDLE/VALID is ignored.
- pc_load outside IDLE and the handshake cycle is ignored.
- rst overrides everything in any state, including mid-fetch with mem_rd high: next cycle all outputs take reset values.
- ir_half = mem_rdata always. The IR samples it only when ir_e & ir_funsel==01.

Decomposition:
- Package ir_fetch_pkg holds:
  - state encoding: IDLE = 2'd0, FETCH0 = 2'd1, FETCH1 = 2'd2, VALID = 2'd3;
  - FS_LOAD = 2'b01 and FS_NOP = 2'b00;
  - LH_LOW = 0 and LH_HIGH = 1.
- One natural sub-module, pc_counter (load / increment / rewind, AW-wide with wrap). The FSM and output decode stay in ir_fetch_ctrl.
- Verification instantiates ir_fetch_ctrl with the existing IR_16_bit and a byte-memory model.

Test Plan:
1. Reset, run=1, memory {0x00:0x34, 0x01:0x12}, single-cycle ack, LOW_FIRST=1 -> cycle 1: ir_l_h=0, byte 0x34; cycle 2: ir_l_h=1, byte 0x12; then ir_valid=1, IR = 0x1234, inst_pc = 0x00, pc = 0x02.
2. ir_ready held 1, run=1, three instructions at 0x00/0x02/0x04 -> ir_valid pulses every 3rd cycle; inst_pc 0x00, 0x02, 0x04; no idle cycle between handshake and next mem_rd.
3. mem_ack delayed 3 cycles per byte -> mem_rd and mem_addr stable while waiting; ir_e exactly one cycle per byte; ir_valid after 8 cycles.
4. AW=8, pc_load pc_din=0xFF in IDLE, memory {0xFF:0xCD, 0x00:0xAB} -> IR = 0xABCD, inst_pc = 0xFF, pc wraps to 0x01.
5. flush in FETCH1 cycle with mem_ack=1 -> no ir_e that cycle, state IDLE, pc rewound to inst_pc, IR high byte unchanged.
6. Handshake with pc_load=1, pc_din=0x40, run=0 -> state IDLE, pc = 0x40; then run=1 -> mem_addr = 0x40. Also: rst asserted mid-FETCH0 -> next cycle mem_rd=0, pc = RESET_PC.
